// File: rtl/debugger_response_tx_pkg.sv
// Shared debug-unit definitions: FSM encodings, response size codes, clock-strobe
// command codes and byte-ordering helpers used by the response serialiser.
package debugger_response_tx_pkg;

  localparam logic [2:0] ST_IDLE_ENC = 3'd0;
  localparam logic [2:0] ST_SEND_ENC = 3'd1;
  localparam logic [2:0] ST_WAIT_ENC = 3'd2;
  localparam logic [2:0] ST_FIN_ENC  = 3'd3;
  localparam logic [2:0] ST_ERR_ENC  = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE = ST_IDLE_ENC,
    ST_SEND = ST_SEND_ENC,
    ST_WAIT = ST_WAIT_ENC,
    ST_FIN  = ST_FIN_ENC,
    ST_ERR  = ST_ERR_ENC
  } tx_state_e;

  localparam logic [1:0] SZ_1B = 2'b00;
  localparam logic [1:0] SZ_2B = 2'b01;
  localparam logic [1:0] SZ_3B = 2'b10;
  localparam logic [1:0] SZ_4B = 2'b11;

  localparam logic [5:0] CMD_CLK_STROBE_0 = 6'b111000;
  localparam logic [5:0] CMD_CLK_STROBE_1 = 6'b111111;

  // MSB-first words are pre-shifted so the most-significant valid byte sits in [31:24].
  function automatic logic [31:0] align_result(input logic [31:0] w, input logic [1:0] sz,
                                               input bit lsb_first);
    logic [4:0] sh;
    sh = {2'd3 - sz, 3'b000};
    return lsb_first ? w : (w << sh);
  endfunction

  function automatic logic [7:0] head_byte(input logic [31:0] w, input bit lsb_first);
    return lsb_first ? w[7:0] : w[31:24];
  endfunction

endpackage

// File: rtl/debugger_response_tx_watchdog.sv
// Per-byte timeout counter for the response serialiser; a limit of 0 disables it.
module debug_tx_watchdog
  import debugger_response_tx_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);
  localparam bit ACTIVE = (TIMEOUT_CYCLES != 0);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (ACTIVE && enable && !expired) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign expired = ACTIVE && enable && (cnt_q == LIMIT);

endmodule

// File: rtl/debugger_response_tx.sv
// Serialises a 32-bit decoder result into 1..4 bytes for the UART byte transmitter,
// with one tx_start per byte and a per-byte tx_done timeout.
module debugger_response_tx
  import debugger_response_tx_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter bit          LSB_FIRST      = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] result,
  input  logic [1:0]  size,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_done,
  output logic        busy,
  output logic        done,
  output logic        abort
);

  tx_state_e   state_q;
  logic [31:0] shreg_q;
  logic [1:0]  bytes_left_q;
  logic [7:0]  tx_data_q;
  logic        tx_start_q;
  logic        busy_q;
  logic        done_q;
  logic        abort_q;

  logic [31:0] aligned_d;
  logic [31:0] shifted_d;
  logic        wd_clear;
  logic        wd_enable;
  logic        wd_expired;

  assign aligned_d = align_result(result, size, LSB_FIRST);
  assign shifted_d = LSB_FIRST ? (shreg_q >> 8) : (shreg_q << 8);

  // A tx_done in the same cycle as expiry keeps the watchdog disabled, so the byte completes.
  assign wd_clear  = (state_q == ST_SEND);
  assign wd_enable = (state_q == ST_WAIT) && !tx_done;

  debug_tx_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (wd_clear),
    .enable (wd_enable),
    .expired(wd_expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      shreg_q      <= '0;
      bytes_left_q <= '0;
      tx_data_q    <= '0;
      tx_start_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      abort_q      <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      done_q     <= 1'b0;
      abort_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            shreg_q      <= aligned_d;
            bytes_left_q <= size;
            tx_data_q    <= head_byte(aligned_d, LSB_FIRST);
            tx_start_q   <= 1'b1;
            busy_q       <= 1'b1;
            state_q      <= ST_SEND;
          end
        end
        ST_SEND: begin
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (tx_done) begin
            if (bytes_left_q == 2'd0) begin
              done_q  <= 1'b1;
              state_q <= ST_FIN;
            end else begin
              shreg_q      <= shifted_d;
              bytes_left_q <= bytes_left_q - 2'd1;
              tx_data_q    <= head_byte(shifted_d, LSB_FIRST);
              tx_start_q   <= 1'b1;
              state_q      <= ST_SEND;
            end
          end else if (wd_expired) begin
            abort_q <= 1'b1;
            state_q <= ST_ERR;
          end
        end
        ST_FIN, ST_ERR: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign abort    = abort_q;

endmodule
